// File: rtl/adc_pkg.sv
// Shared constants and types for the LTC1407A-style ADC serial capture path.
// The acquisition controller imports SAMPLE_W from here as well.
package adc_pkg;

  localparam int unsigned SAMPLE_W     = 14;
  localparam int unsigned FRAME_BITS   = 34;
  localparam int unsigned A_FIRST_EDGE = 3;
  localparam int unsigned B_FIRST_EDGE = 19;
  localparam int unsigned BIT_CNT_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True when the SCK rise with zero-based index cnt falls in a sample's 14-edge window.
  function automatic logic in_window(input logic [BIT_CNT_W-1:0] cnt,
                                     input int unsigned first_edge);
    return (32'(cnt) >= (first_edge - 1)) && (32'(cnt) < (first_edge - 1 + SAMPLE_W));
  endfunction

endpackage

// File: rtl/sck_gen.sv
// SPI clock divider: registered SCK (idles low) with strobes flagging the
// system edge on which SCK will rise or fall.
module sck_gen #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise_stb_c,
  output logic o_fall_stb_c
);

  localparam int unsigned   PH_W    = $clog2(HALF_PERIOD) + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

  logic [PH_W-1:0] r_phase;
  logic            r_sck;
  logic            w_half_end;

  assign w_half_end   = i_en && (r_phase == PH_LAST);
  assign o_rise_stb_c = w_half_end && !r_sck;
  assign o_fall_stb_c = w_half_end && r_sck;
  assign o_sck        = r_sck;

  // Disabled divider parks SCK low with phase zeroed so every frame starts identically.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
      r_sck   <= 1'b0;
    end else if (!i_en) begin
      r_phase <= '0;
      r_sck   <= 1'b0;
    end else if (w_half_end) begin
      r_phase <= '0;
      r_sck   <= ~r_sck;
    end else begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// Dual-channel ADC front end: pulses ad_conv, clocks in one 34-bit SPI frame
// and publishes both 14-bit samples together with a one-cycle adc_done.
module adc_spi_capture
  import adc_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2,
  parameter int unsigned CONV_CYCLES = 2
) (
  input  logic                CLK50MHZ,
  input  logic                RST_N,
  input  logic                adc_trig,
  output logic                adc_done,
  output logic [SAMPLE_W-1:0] adc_a,
  output logic [SAMPLE_W-1:0] adc_b,
  output logic                busy,
  output logic                ad_conv,
  output logic                spi_sck,
  input  logic                spi_miso
);

  localparam int unsigned          CC_W      = $clog2(CONV_CYCLES) + 1;
  localparam logic [CC_W-1:0]      CONV_LAST = CC_W'(CONV_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(FRAME_BITS - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [CC_W-1:0]      r_conv_cnt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [SAMPLE_W-1:0]  r_shadow_a;
  logic [SAMPLE_W-1:0]  r_shadow_b;
  logic                 w_sck_en;
  logic                 w_rise_stb;
  logic                 w_fall_stb;
  logic                 w_done_d;
  logic                 w_busy_d;
  logic                 w_conv_d;
  logic                 r_adc_done;
  logic                 r_busy;
  logic                 r_ad_conv;
  logic [SAMPLE_W-1:0]  r_adc_a;
  logic [SAMPLE_W-1:0]  r_adc_b;

  assign w_sck_en = (r_state == ST_SHIFT);

  sck_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_sck_gen (
    .i_clk       (CLK50MHZ),
    .i_rst_n     (RST_N),
    .i_en        (w_sck_en),
    .o_sck       (spi_sck),
    .o_rise_stb_c(w_rise_stb),
    .o_fall_stb_c(w_fall_stb)
  );

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (adc_trig) w_next_state = ST_CONV;
      ST_CONV:  if (r_conv_cnt == CONV_LAST) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_fall_stb && (r_bit_cnt == BIT_LAST)) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output flops are loaded from the next state so each pin lines up with its state.
  always_comb begin
    w_done_d = 1'b0;
    w_busy_d = 1'b0;
    w_conv_d = 1'b0;
    if (w_next_state == ST_DONE) w_done_d = 1'b1;
    if (w_next_state != ST_IDLE) w_busy_d = 1'b1;
    if (w_next_state == ST_CONV) w_conv_d = 1'b1;
  end

  // Bit counter advances on SCK falls, so rise k always sees count k-1 and never wraps.
  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_conv_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (r_state == ST_CONV) r_conv_cnt <= r_conv_cnt + CC_W'(1);
      else                    r_conv_cnt <= '0;
      if (r_state != ST_SHIFT)                    r_bit_cnt <= '0;
      else if (w_fall_stb && (r_bit_cnt != BIT_LAST)) r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_shadow_a <= '0;
      r_shadow_b <= '0;
    end else if (r_state == ST_IDLE) begin
      r_shadow_a <= '0;
      r_shadow_b <= '0;
    end else if (w_rise_stb) begin
      if (in_window(r_bit_cnt, A_FIRST_EDGE)) r_shadow_a <= {r_shadow_a[SAMPLE_W-2:0], spi_miso};
      if (in_window(r_bit_cnt, B_FIRST_EDGE)) r_shadow_b <= {r_shadow_b[SAMPLE_W-2:0], spi_miso};
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_adc_done <= 1'b0;
      r_busy     <= 1'b0;
      r_ad_conv  <= 1'b0;
      r_adc_a    <= '0;
      r_adc_b    <= '0;
    end else begin
      r_adc_done <= w_done_d;
      r_busy     <= w_busy_d;
      r_ad_conv  <= w_conv_d;
      if (w_done_d) begin
        r_adc_a <= r_shadow_a;
        r_adc_b <= r_shadow_b;
      end
    end
  end

  assign adc_done = r_adc_done;
  assign busy     = r_busy;
  assign ad_conv  = r_ad_conv;
  assign adc_a    = r_adc_a;
  assign adc_b    = r_adc_b;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: three instances (HALF_PERIOD 2, 1, 3), each fed by a
// behavioural ADC that shifts out {2 dummies, A, 2 dummies, B, 2 dummies} MSB first.
module tb_adc_spi_capture;

  localparam int unsigned NINST = 3;
  localparam int unsigned CONV  = 2;

  typedef struct {
    int         inst;
    logic [13:0] a;
    logic [13:0] b;
    logic [5:0]  dmy;
    int         extra_at;
    logic [13:0] exp_a;
    logic [13:0] exp_b;
    int         exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig_w [NINST];
  logic        done_w [NINST];
  logic        busy_w [NINST];
  logic        conv_w [NINST];
  logic        sck_w  [NINST];
  logic [13:0] a_w    [NINST];
  logic [13:0] b_w    [NINST];
  logic [33:0] frame_v [NINST];

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  function automatic int hp_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
  endfunction

  // Trigger edge to done: one accept edge, the conversion pulse, then 68 SCK half-periods.
  function automatic int lat_of(input int i);
    return 1 + CONV + 68 * hp_of(i);
  endfunction

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    localparam int unsigned HP = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    logic miso = 1'b0;
    int   idx  = 0;

    adc_spi_capture #(
      .HALF_PERIOD(HP),
      .CONV_CYCLES(CONV)
    ) u_dut (
      .CLK50MHZ(clk),
      .RST_N   (rst_n),
      .adc_trig(trig_w[g]),
      .adc_done(done_w[g]),
      .adc_a   (a_w[g]),
      .adc_b   (b_w[g]),
      .busy    (busy_w[g]),
      .ad_conv (conv_w[g]),
      .spi_sck (sck_w[g]),
      .spi_miso(miso)
    );

    // ADC presents the first bit at conversion start, then the next bit after each SCK fall.
    always @(posedge conv_w[g] or negedge sck_w[g]) begin
      if (conv_w[g]) begin
        idx  = 0;
        miso = frame_v[g][33];
      end else begin
        idx = idx + 1;
        if (idx < 34) miso = frame_v[g][33 - idx];
      end
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Caller sits #1 after an edge with instance i idle; returns #1 after the edge following done.
  task automatic run_frame(input int i, input logic [13:0] a, input logic [13:0] b,
                           input logic [5:0] dmy, input int extra_at,
                           input logic [13:0] exp_a, input logic [13:0] exp_b,
                           input int exp_lat, input string tag);
    int   n, conv_hi, conv_rise, rises, busy_gap, limit;
    logic prev_sck, prev_conv, stable_ok, done_seen, late_conv;
    logic [13:0] old_a, old_b;
    frame_v[i] = {dmy[5:4], a, dmy[3:2], b, dmy[1:0]};
    old_a = a_w[i];
    old_b = b_w[i];
    trig_w[i] = 1'b1;
    @(posedge clk); #1;
    n = 1; conv_hi = 0; conv_rise = 0; rises = 0; busy_gap = 0;
    prev_sck = 1'b0; prev_conv = 1'b0; stable_ok = 1'b1; done_seen = 1'b0;
    limit = exp_lat + 40;
    while (n <= limit) begin
      trig_w[i] = (n == extra_at);
      if (conv_w[i]) conv_hi++;
      if (conv_w[i] && !prev_conv) conv_rise++;
      if (sck_w[i] && !prev_sck) rises++;
      if (!busy_w[i]) busy_gap++;
      prev_conv = conv_w[i];
      prev_sck  = sck_w[i];
      if (done_w[i]) begin
        done_seen = 1'b1;
        break;
      end
      if ((a_w[i] !== old_a) || (b_w[i] !== old_b)) stable_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    trig_w[i] = 1'b0;
    chk({tag, " done_seen"}, 32'(done_seen), 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " conv_cycles"}, 32'(conv_hi), 32'(CONV));
    chk({tag, " conv_pulses"}, 32'(conv_rise), 32'd1);
    chk({tag, " sck_rises"}, 32'(rises), 32'd34);
    chk({tag, " busy_gaps"}, 32'(busy_gap), 32'd0);
    chk({tag, " held_before_done"}, 32'(stable_ok), 32'd1);
    chk({tag, " adc_a"}, 32'(a_w[i]), 32'(exp_a));
    chk({tag, " adc_b"}, 32'(b_w[i]), 32'(exp_b));
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 32'(done_w[i]), 32'd0);
    chk({tag, " busy_after"}, 32'(busy_w[i]), 32'd0);
    chk({tag, " adc_a_held"}, 32'(a_w[i]), 32'(exp_a));
    if (extra_at != 0) begin
      late_conv = 1'b0;
      repeat (6) begin
        if (conv_w[i] || done_w[i] || busy_w[i]) late_conv = 1'b1;
        @(posedge clk); #1;
      end
      chk({tag, " trig_not_queued"}, 32'(late_conv), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input int i, input string tag);
    chk({tag, " done"}, 32'(done_w[i]), 32'd0);
    chk({tag, " busy"}, 32'(busy_w[i]), 32'd0);
    chk({tag, " ad_conv"}, 32'(conv_w[i]), 32'd0);
    chk({tag, " spi_sck"}, 32'(sck_w[i]), 32'd0);
    chk({tag, " adc_a"}, 32'(a_w[i]), 32'd0);
    chk({tag, " adc_b"}, 32'(b_w[i]), 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic [13:0] ra, rb;

    for (int i = 0; i < NINST; i++) begin
      trig_w[i]  = 1'b0;
      frame_v[i] = '0;
    end

    vecs.push_back('{0, 14'h2001, 14'h1FFF, 6'h3F, 0, 14'h2001, 14'h1FFF, lat_of(0)});
    vecs.push_back('{0, 14'h0000, 14'h0000, 6'b101010, 0, 14'h0000, 14'h0000, lat_of(0)});
    vecs.push_back('{0, 14'h3FFF, 14'h0000, 6'h15, 50, 14'h3FFF, 14'h0000, lat_of(0)});
    vecs.push_back('{0, 14'h0001, 14'h2000, 6'h00, 0, 14'h0001, 14'h2000, lat_of(0)});
    for (int k = 0; k < 6; k++) begin
      ra = 14'($urandom);
      rb = 14'($urandom);
      v  = '{1 + (k / 3), ra, rb, 6'($urandom), 0, ra, rb, lat_of(1 + (k / 3))};
      vecs.push_back(v);
    end
    ra = 14'($urandom);
    rb = 14'($urandom);
    vecs.push_back('{0, ra, rb, 6'($urandom), 0, ra, rb, lat_of(0)});

    #5;
    for (int i = 0; i < NINST; i++) chk_reset_outputs(i, $sformatf("por%0d", i));
    #38 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < vecs.size(); k++) begin
      run_frame(vecs[k].inst, vecs[k].a, vecs[k].b, vecs[k].dmy, vecs[k].extra_at,
                vecs[k].exp_a, vecs[k].exp_b, vecs[k].exp_lat, $sformatf("vec%0d", k));
    end

    // Asynchronous reset while idle with non-zero samples held.
    run_frame(0, 14'h1234, 14'h0ABC, 6'h2A, 0, 14'h1234, 14'h0ABC, lat_of(0), "pre_idle_rst");
    #4 rst_n = 1'b0;
    #1 chk_reset_outputs(0, "idle_rst");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset 70 cycles into a frame, then a clean frame.
    run_frame(0, 14'h2AAA, 14'h1555, 6'h3F, 0, 14'h2AAA, 14'h1555, lat_of(0), "pre_mid_rst");
    frame_v[0] = {2'b11, 14'h0F0F, 2'b11, 14'h30F0, 2'b11};
    trig_w[0] = 1'b1;
    @(posedge clk); #1;
    trig_w[0] = 1'b0;
    repeat (69) @(posedge clk);
    #1 chk("mid_rst busy_before", 32'(busy_w[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs(0, "mid_rst");
    repeat (2) @(posedge clk);
    #1 chk("mid_rst sck_held", 32'(sck_w[0]), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0, 14'h0F0F, 14'h30F0, 6'h3F, 0, 14'h0F0F, 14'h30F0, lat_of(0), "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
